// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port data memory
// between requester A (core) and requester B (DMA/debug).
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  A_Req,
    input  logic                  A_Write,
    input  logic [ADDR_WIDTH-1:0] A_Addr,
    input  logic [DATA_WIDTH-1:0] A_Wdata,
    output logic                  A_Gnt,
    output logic                  A_Rvalid,
    output logic [DATA_WIDTH-1:0] A_Rdata,
    output logic                  A_Err,
    input  logic                  B_Req,
    input  logic                  B_Write,
    input  logic [ADDR_WIDTH-1:0] B_Addr,
    input  logic [DATA_WIDTH-1:0] B_Wdata,
    output logic                  B_Gnt,
    output logic                  B_Rvalid,
    output logic [DATA_WIDTH-1:0] B_Rdata,
    output logic                  B_Err,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0] Mem_Write_data,
    output logic                  Mem_Write,
    output logic                  Mem_Read,
    input  logic [DATA_WIDTH-1:0] Mem_Read_data
);

    localparam int unsigned CNT_W = 3;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    last_b_q, last_b_d;
    logic                    win_b_q, win_b_d;
    logic                    wr_q, wr_d;
    logic                    oor_q, oor_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic                    a_err_q, a_err_d, b_err_q, b_err_d;
    logic                    a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    mem_write_q, mem_write_d;
    logic                    mem_read_q, mem_read_d;

    logic                    sel_b;
    logic                    req_wr;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    req_in_rng;

    // Winner selection: lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        sel_b      = B_Req && (!A_Req || !last_b_q);
        req_wr     = sel_b ? B_Write : A_Write;
        req_addr   = sel_b ? B_Addr  : A_Addr;
        req_wdata  = sel_b ? B_Wdata : A_Wdata;
        req_in_rng = (req_addr < DEPTH_A);
    end

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        win_b_d     = win_b_q;
        wr_d        = wr_q;
        oor_d       = oor_q;
        cnt_d       = cnt_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_err_d     = 1'b0;
        b_err_d     = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (A_Req || B_Req) begin
                    win_b_d  = sel_b;
                    last_b_d = sel_b;
                    wr_d     = req_wr;
                    oor_d    = !req_in_rng;
                    a_gnt_d  = !sel_b;
                    b_gnt_d  = sel_b;
                    a_err_d  = !sel_b && !req_in_rng;
                    b_err_d  = sel_b && !req_in_rng;
                    if (req_in_rng) begin
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        mem_write_d = req_wr;
                        mem_read_d  = !req_wr;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    state_d = S_IDLE;
                end else if (oor_q) begin
                    // Rejected read answers with zero data and no memory access.
                    a_rvalid_d = !win_b_q;
                    b_rvalid_d = win_b_q;
                    if (win_b_q) b_rdata_d = '0;
                    else         a_rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    a_rvalid_d = !win_b_q;
                    b_rvalid_d = win_b_q;
                    if (win_b_q) b_rdata_d = Mem_Read_data;
                    else         a_rdata_d = Mem_Read_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; A wins the first tie.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            last_b_q    <= 1'b1;
            win_b_q     <= 1'b0;
            wr_q        <= 1'b0;
            oor_q       <= 1'b0;
            cnt_q       <= '0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            win_b_q     <= win_b_d;
            wr_q        <= wr_d;
            oor_q       <= oor_d;
            cnt_q       <= cnt_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            a_err_q     <= a_err_d;
            b_err_q     <= b_err_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign A_Gnt          = a_gnt_q;
    assign B_Gnt          = b_gnt_q;
    assign A_Err          = a_err_q;
    assign B_Err          = b_err_q;
    assign A_Rvalid       = a_rvalid_q;
    assign B_Rvalid       = b_rvalid_q;
    assign A_Rdata        = a_rdata_q;
    assign B_Rdata        = b_rdata_q;
    assign Mem_Address    = mem_addr_q;
    assign Mem_Write_data = mem_wdata_q;
    assign Mem_Write      = mem_write_q;
    assign Mem_Read       = mem_read_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: two instances (READ_LATENCY 1 and 3) share
// stimulus; each has its own memory model and read-data scoreboards.
module tb_data_memory_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;

    logic          Clk;
    logic          Reset;
    logic          A_Req, A_Write, B_Req, B_Write;
    logic [AW-1:0] A_Addr, B_Addr;
    logic [DW-1:0] A_Wdata, B_Wdata;

    logic          a_gnt1, a_rvalid1, a_err1, b_gnt1, b_rvalid1, b_err1, mw1, mr1;
    logic [DW-1:0] a_rdata1, b_rdata1, mwd1, mrd1;
    logic [AW-1:0] ma1;
    logic          a_gnt3, a_rvalid3, a_err3, b_gnt3, b_rvalid3, b_err3, mw3, mr3;
    logic [DW-1:0] a_rdata3, b_rdata3, mwd3, mrd3;
    logic [AW-1:0] ma3;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] q_a1[$], q_b1[$], q_a3[$], q_b3[$];

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_Wdata(A_Wdata),
        .A_Gnt(a_gnt1), .A_Rvalid(a_rvalid1), .A_Rdata(a_rdata1), .A_Err(a_err1),
        .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_Wdata(B_Wdata),
        .B_Gnt(b_gnt1), .B_Rvalid(b_rvalid1), .B_Rdata(b_rdata1), .B_Err(b_err1),
        .Mem_Address(ma1), .Mem_Write_data(mwd1), .Mem_Write(mw1), .Mem_Read(mr1),
        .Mem_Read_data(mrd1)
    );

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(3)) u_dut3 (
        .Clk(Clk), .Reset(Reset),
        .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_Wdata(A_Wdata),
        .A_Gnt(a_gnt3), .A_Rvalid(a_rvalid3), .A_Rdata(a_rdata3), .A_Err(a_err3),
        .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_Wdata(B_Wdata),
        .B_Gnt(b_gnt3), .B_Rvalid(b_rvalid3), .B_Rdata(b_rdata3), .B_Err(b_err3),
        .Mem_Address(ma3), .Mem_Write_data(mwd3), .Mem_Write(mw3), .Mem_Read(mr3),
        .Mem_Read_data(mrd3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory models: data is valid READ_LATENCY cycles after the Mem_Read cycle, junk otherwise.
    logic [DW-1:0] mem1 [0:DEPTH-1];
    logic [DW-1:0] mem3 [0:DEPTH-1];
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [0:2];

    always @(posedge Clk) begin
        if (mw1) mem1[ma1[4:0]] <= mwd1;
        pipe1 <= mr1 ? mem1[ma1[4:0]] : 32'hDEAD_0001;
        if (mw3) mem3[ma3[4:0]] <= mwd3;
        pipe3[0] <= mr3 ? mem3[ma3[4:0]] : 32'hDEAD_0003;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mrd1 = pipe1;
    assign mrd3 = pipe3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on read responses, plus grant/response exclusivity.
    always @(negedge Clk) begin
        if (a_rvalid1) begin
            if (q_a1.size() == 0) chk("a1_unexpected_rvalid", 32'(1), 32'(0));
            else                  chk("a1_rdata", a_rdata1, q_a1.pop_front());
        end
        if (b_rvalid1) begin
            if (q_b1.size() == 0) chk("b1_unexpected_rvalid", 32'(1), 32'(0));
            else                  chk("b1_rdata", b_rdata1, q_b1.pop_front());
        end
        if (a_rvalid3) begin
            if (q_a3.size() == 0) chk("a3_unexpected_rvalid", 32'(1), 32'(0));
            else                  chk("a3_rdata", a_rdata3, q_a3.pop_front());
        end
        if (b_rvalid3) begin
            if (q_b3.size() == 0) chk("b3_unexpected_rvalid", 32'(1), 32'(0));
            else                  chk("b3_rdata", b_rdata3, q_b3.pop_front());
        end
        if (a_gnt1 | b_gnt1) chk("gnt_excl1", 32'(a_gnt1 & b_gnt1), 32'(0));
        if (a_gnt3 | b_gnt3) chk("gnt_excl3", 32'(a_gnt3 & b_gnt3), 32'(0));
        if (a_rvalid1 | b_rvalid1) chk("rvalid_excl1", 32'(a_rvalid1 & b_rvalid1), 32'(0));
        if (a_rvalid3 | b_rvalid3) chk("rvalid_excl3", 32'(a_rvalid3 & b_rvalid3), 32'(0));
    end

    function automatic logic [7:0] flags1();
        return {a_gnt1, a_err1, a_rvalid1, b_gnt1, b_err1, b_rvalid1, mw1, mr1};
    endfunction

    function automatic logic [7:0] flags3();
        return {a_gnt3, a_err3, a_rvalid3, b_gnt3, b_err3, b_rvalid3, mw3, mr3};
    endfunction

    // Expected strobe vector k cycles after the request is sampled in IDLE.
    function automatic logic [7:0] exp_flags(input int k, input bit is_b, input bit wr,
                                             input bit oor, input int lat);
        bit g, e, r;
        g = (k == 1);
        e = g && oor;
        r = !wr && (k == (oor ? 2 : 2 + lat));
        return {g && !is_b, e && !is_b, r && !is_b, g && is_b, e && is_b, r && is_b,
                g && wr && !oor, g && !wr && !oor};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags1"}, 32'(flags1()), 32'(0));
        chk({tag, "_flags3"}, 32'(flags3()), 32'(0));
        chk({tag, "_rdata1"}, a_rdata1 | b_rdata1, 32'(0));
        chk({tag, "_rdata3"}, a_rdata3 | b_rdata3, 32'(0));
        chk({tag, "_mem1"}, ma1 | mwd1, 32'(0));
        chk({tag, "_mem3"}, ma3 | mwd3, 32'(0));
    endtask

    // One transaction from a single requester, checked cycle by cycle on both instances.
    task automatic txn(input bit is_b, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
        bit            oor;
        logic [DW-1:0] rd;
        oor = (addr >= AW'(DEPTH));
        @(negedge Clk);
        if (is_b) begin
            B_Req = 1'b1; B_Write = wr; B_Addr = addr; B_Wdata = wd;
        end else begin
            A_Req = 1'b1; A_Write = wr; A_Addr = addr; A_Wdata = wd;
        end
        if (!wr) begin
            rd = oor ? '0 : ref_mem[addr[4:0]];
            if (is_b) begin q_b1.push_back(rd); q_b3.push_back(rd); end
            else      begin q_a1.push_back(rd); q_a3.push_back(rd); end
        end else if (!oor) begin
            ref_mem[addr[4:0]] = wd;
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            if (k == 1) begin A_Req = 1'b0; B_Req = 1'b0; end
            chk($sformatf("flags1_k%0d", k), 32'(flags1()), 32'(exp_flags(k, is_b, wr, oor, 1)));
            chk($sformatf("flags3_k%0d", k), 32'(flags3()), 32'(exp_flags(k, is_b, wr, oor, 3)));
            if (k == 1 && !oor) begin
                chk("mem_addr1", ma1, addr);
                chk("mem_addr3", ma3, addr);
                chk("mem_wdata1", mwd1, wd);
                chk("mem_wdata3", mwd3, wd);
            end
        end
    endtask

    initial begin
        logic [7:0] ef;
        Reset = 1'b1;
        A_Req = 1'b0; A_Write = 1'b0; A_Addr = '0; A_Wdata = '0;
        B_Req = 1'b0; B_Write = 1'b0; B_Addr = '0; B_Wdata = '0;
        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        Reset = 1'b0;

        txn(1'b0, 1'b1, 32'd5, 32'h0000_1234);      // A write
        txn(1'b0, 1'b0, 32'd5, 32'h0000_0000);      // A read back
        txn(1'b1, 1'b1, 32'd7, 32'h0000_BEEF);      // B write
        txn(1'b1, 1'b0, 32'd7, 32'h0000_0000);      // B read back
        txn(1'b1, 1'b0, 32'd40, 32'h0000_0000);     // B read out of range
        txn(1'b1, 1'b1, 32'd50, 32'h5555_5555);     // B write out of range
        txn(1'b0, 1'b0, 32'h8000_0003, 32'h0);      // A read, high address bit set
        txn(1'b0, 1'b0, 32'd7, 32'h0000_0000);      // A reads B's data
        txn(1'b1, 1'b1, 32'd31, 32'hCAFE_F00D);     // last legal address
        txn(1'b1, 1'b0, 32'd31, 32'h0000_0000);
        txn(1'b1, 1'b0, 32'd32, 32'h0000_0000);     // first illegal address

        // Both request continuously: grants alternate A, B, A, B.
        @(negedge Clk);
        A_Req = 1'b1; A_Write = 1'b1; A_Addr = 32'd10; A_Wdata = 32'hAAAA_0010;
        B_Req = 1'b1; B_Write = 1'b1; B_Addr = 32'd11; B_Wdata = 32'hBBBB_0011;
        ref_mem[10] = 32'hAAAA_0010;
        ref_mem[11] = 32'hBBBB_0011;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (k == 7) begin A_Req = 1'b0; B_Req = 1'b0; end
            ef = {(k == 1 || k == 5), 1'b0, 1'b0, (k == 3 || k == 7), 1'b0, 1'b0, (k % 2 == 1), 1'b0};
            chk($sformatf("rr_flags1_k%0d", k), 32'(flags1()), 32'(ef));
            chk($sformatf("rr_flags3_k%0d", k), 32'(flags3()), 32'(ef));
            if (k % 2 == 1) chk($sformatf("rr_addr1_k%0d", k), ma1, (k == 1 || k == 5) ? 32'd10 : 32'd11);
        end
        txn(1'b0, 1'b0, 32'd11, 32'h0);
        txn(1'b1, 1'b0, 32'd10, 32'h0);

        // Reset while an A read is waiting on memory: the read is dropped.
        @(negedge Clk);
        A_Req = 1'b1; A_Write = 1'b0; A_Addr = 32'd5;
        @(negedge Clk);
        A_Req = 1'b0;
        chk("rst_pre_gnt1", 32'(a_gnt1), 32'(1));
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk_all_zero("midreset");
        Reset = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            @(negedge Clk);
            chk($sformatf("post_rst1_k%0d", k), 32'(flags1()), 32'(0));
            chk($sformatf("post_rst3_k%0d", k), 32'(flags3()), 32'(0));
        end

        // First tie after reset goes to A.
        A_Req = 1'b1; A_Write = 1'b1; A_Addr = 32'd12; A_Wdata = 32'h0000_0012;
        B_Req = 1'b1; B_Write = 1'b1; B_Addr = 32'd13; B_Wdata = 32'h0000_0013;
        ref_mem[12] = 32'h0000_0012;
        ref_mem[13] = 32'h0000_0013;
        @(negedge Clk);
        chk("tie_a_first1", 32'({a_gnt1, b_gnt1}), 32'(2'b10));
        chk("tie_a_first3", 32'({a_gnt3, b_gnt3}), 32'(2'b10));
        A_Req = 1'b0;
        repeat (2) @(negedge Clk);
        chk("tie_b_next1", 32'({a_gnt1, b_gnt1}), 32'(2'b01));
        chk("tie_b_next3", 32'({a_gnt3, b_gnt3}), 32'(2'b01));
        B_Req = 1'b0;
        repeat (2) @(negedge Clk);
        txn(1'b0, 1'b0, 32'd13, 32'h0);
        txn(1'b1, 1'b0, 32'd12, 32'h0);

        chk("sb_left1", 32'(q_a1.size() + q_b1.size()), 32'(0));
        chk("sb_left3", 32'(q_a3.size() + q_b3.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory.
- Shares the memory between requester A (core load/store path) and requester B (DMA/debug path), one transaction at a time.
- Uses round-robin fairness, a registered issue stage, a fixed read-latency wait, and out-of-range address rejection.

Parameters:
- ADDR_WIDTH, 32, width of requester and memory address.
- DATA_WIDTH, 32, width of write/read data.
- DEPTH, 32, number of memory words; addresses >= DEPTH are rejected.
- READ_LATENCY, 1, cycles from Mem_Read asserted to Mem_Read_data valid; legal range 1..4.

Ports:
- Clk  in  1  single clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- A_Req  in  1  A request; Addr/Write/Wdata held stable until A_Gnt.
- A_Write  in  1  1=write, 0=read.
- A_Addr  in  ADDR_WIDTH  A word address.
- A_Wdata  in  DATA_WIDTH  A write data.
- A_Gnt  out  1  one-cycle pulse; A request accepted.
- A_Rvalid  out  1  one-cycle pulse; A_Rdata valid.
- A_Rdata  out  DATA_WIDTH  A read data.
- A_Err  out  1  one-cycle pulse with Gnt; address out of range.
- B_Req, B_Write, B_Addr, B_Wdata, B_Gnt, B_Rvalid, B_Rdata, B_Err: same as A for requester B.
- Mem_Address  out  ADDR_WIDTH  memory address.
- Mem_Write_data  out  DATA_WIDTH  memory write data.
- Mem_Write  out  1  memory write strobe, one cycle.
- Mem_Read  out  1  memory read strobe, one cycle.
- Mem_Read_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset:
  - State=IDLE, Last_grant=B, so A wins the first tie.
  - All outputs 0, including Mem_* buses and Rdata.
  - Reset mid-transaction drops it: no Gnt, Rvalid or Err for the dropped request.
- State IDLE (cycle T):
  - Sample Req lines.
  - Single requester: it wins.
  - Both requesting: winner = requester != Last_grant.
  - Latch winner's Write/Addr/Wdata. Set Last_grant=winner. Go to ISSUE.
  - No Req: stay IDLE.
- State ISSUE (cycle T+1):
  - Winner's Gnt pulses high.
  - In range (Addr < DEPTH):
    - Mem_Address and Mem_Write_data driven from latched values.
    - Write: Mem_Write=1 this cycle only; next state IDLE.
    - Read: Mem_Read=1 this cycle only; load latency counter with READ_LATENCY; next state WAIT.
  - Out of range:
    - No Mem_Write/Mem_Read.
    - Err pulses with Gnt.
    - Read: next state RESP with data 0, no memory access.
    - Write: next state IDLE.
- State WAIT:
  - Counter decrements each cycle.
  - At counter==1, capture Mem_Read_data into the winner's Rdata register; next state RESP.
- State RESP (cycle T+2+READ_LATENCY for reads):
  - Winner's Rvalid pulses high for one cycle.
  - Rdata holds the value until the next read response to that port.
  - Next state IDLE.
- Mem_Address and Mem_Write_data hold their last value outside ISSUE. Strobes are 0 outside ISSUE.
- Throughput:
  - Write: 2 cycles.
  - Read: 3+READ_LATENCY cycles, IDLE cycle included.
  - Only one outstanding transaction; the non-winner waits with Req held.
- Requester dropping Req before Gnt: the latched request still completes. Requesters must not do this.
- Req sampled during ISSUE, WAIT or RESP is ignored until IDLE.
- A_Gnt and B_Gnt are never high together; likewise Rvalid and Err.
- Address compare uses the full ADDR_WIDTH unsigned value.

Test Plan:
- Reset, then A write Addr=5, Wdata=0x1234:
  - A_Gnt at T+1.
  - Mem_Write=1 with Mem_Address=5, Mem_Write_data=0x1234 in the same cycle.
  - No Rvalid.
- A read Addr=5 with model memory returning 0x1234, READ_LATENCY=1:
  - Mem_Read at T+1.
  - A_Rvalid at T+3 with A_Rdata=0x1234.
- A and B both request continuously, 4 transactions:
  - Grants in order A, B, A, B; never both Gnt in one cycle.
- B read Addr=40 (DEPTH=32):
  - B_Gnt and B_Err at T+1; no Mem_Read.
  - B_Rvalid at T+2 with B_Rdata=0.
- READ_LATENCY=3, B read Addr=7 returning 0xBEEF:
  - Mem_Read at T+1, capture at T+4.
  - B_Rvalid at T+5 with B_Rdata=0xBEEF.
- Assert Reset during WAIT of an A read:
  - All outputs 0 next cycle; no A_Rvalid.
  - Next simultaneous A/B request grants A first.
